time_entry_fsm: RTL and testbench
=================================

TIME_ENTRY_FSM -- requirements
Module: time_entry_fsm

Interface
REQ-001 Parameter: TMO_CYCLES, default 36_000_000 (3 s at 12 MHz), entry inactivity timeout in clk cycles; 0 disables timeout.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 charData  input  8  ASCII byte; low nibble gives digit value when det_num=1.
REQ-005 det_esc, det_cr, det_num, det_num0to5, det_A, det_L, det_N, det_S, det_atSign  input  1 each  single-cycle key-decode strobes.
REQ-006 dig_m1, dig_m0, dig_s1, dig_s0  output  4 each  committed BCD value mm:ss, registered.
REQ-007 ld_time  output  1  one-cycle pulse: committed digits target the running clock.
REQ-008 ld_alarm  output  1  one-cycle pulse: committed digits target the alarm register.
REQ-009 run_en  output  1  clock run/stop level.
REQ-010 alarm_en  output  1  alarm armed level.
REQ-011 led_sel  output  1  LED display select level.
REQ-012 entry_active  output  1  high while in any entry state.
REQ-013 entry_pos  output  3  digits accepted so far in current entry (0-4).

Function
REQ-014 States: IDLE, E_M1, E_M0, E_S1, E_S0, E_CR; one-hot or binary encoding is implementation choice.
REQ-015 Strobe priority when more than one is high: det_esc > det_cr > det_num > det_A/det_L > det_S/det_N/det_atSign.
REQ-016 IDLE: det_L -> E_M1 with target=time; det_A -> E_M1 with target=alarm; det_S -> run_en=1; det_cr -> run_en=0; det_atSign -> toggle alarm_en; det_N -> toggle led_sel; det_esc, det_num ignored.
REQ-017 E_M1 and E_S1 accept a digit only when det_num0to5=1; E_M0 and E_S0 accept when det_num=1.
REQ-018 Accepted digit loads charData[3:0] into a shadow register for that position, advances E_M1->E_M0->E_S1->E_S0->E_CR, and increments entry_pos.
REQ-019 Rejected digits (e.g. '7' in E_M1) and det_A/L/S/N/atSign in entry states are ignored; state, shadow and entry_pos unchanged.
REQ-020 det_cr in E_CR: copy all four shadow digits to dig_* and return to IDLE; the following cycle emits exactly one of ld_time or ld_alarm per target.
REQ-021 det_cr in E_M1..E_S0 (incomplete entry): treated as abort.
REQ-022 Abort (det_esc in any entry state, incomplete det_cr, or timeout): return to IDLE, entry_pos=0, dig_* unchanged, no load pulse.
REQ-023 Timeout counter clears on entering E_M1 and on every accepted digit; abort when it reaches TMO_CYCLES-1 with no accepted strobe; counter held at 0 in IDLE.
REQ-024 run_en, alarm_en, led_sel unaffected by any entry activity.
REQ-025 A new entry may start in the cycle after ld_* pulses; pulses never overlap or repeat.
REQ-026 entry_active=1 exactly when state != IDLE; entry_pos=0 in IDLE.

Reset
REQ-027 rst forces IDLE, shadow and dig_* = 0, ld_time=ld_alarm=0, run_en=0, alarm_en=0, led_sel=0, entry_pos=0, timeout counter=0, target=time.
REQ-028 rst mid-entry discards partial entry; rst overrides all strobes in the same cycle.

Structure
REQ-029 State encoding and digit-position constants reside in the shared lab package.
REQ-030 Timeout counter implemented as sub-module entry_timer (clear, enable, expire pulse); everything else in time_entry_fsm.

Verification
REQ-031 'l','1','2','3','4',CR -> next cycle ld_time=1 one cycle, dig=1,2:3,4, ld_alarm=0.
REQ-032 'a','6' (rejected), '5','9','0','0',CR -> ld_alarm pulse, dig=5,9:0,0.
REQ-033 'l','1','2',ESC -> IDLE, no pulse, dig_* keep prior 1,2:3,4; 'l','1','2',CR -> same.
REQ-034 IDLE: 's' -> run_en=1; '@' twice -> alarm_en 0->1->0; 'n' -> led_sel=1; CR -> run_en=0.
REQ-035 TMO_CYCLES=100: 'l','1' then idle 100 cycles -> entry_active=0 at expiry, no pulse; rst mid-entry -> all outputs at reset values next cycle.

Source files
------------

// File: rtl/time_entry_fsm_pkg.sv
// rtl/time_entry_fsm_pkg.sv - shared states, targets and digit positions for time entry
package time_entry_fsm_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    E_M1 = 3'd1,
    E_M0 = 3'd2,
    E_S1 = 3'd3,
    E_S0 = 3'd4,
    E_CR = 3'd5
  } state_t;

  typedef enum logic {
    TGT_TIME  = 1'b0,
    TGT_ALARM = 1'b1
  } target_t;

  localparam int NUM_DIGITS = 4;
  localparam logic [1:0] POS_M1 = 2'd0;
  localparam logic [1:0] POS_M0 = 2'd1;
  localparam logic [1:0] POS_S1 = 2'd2;
  localparam logic [1:0] POS_S0 = 2'd3;

  function automatic state_t next_entry(input state_t s);
    case (s)
      E_M1:    return E_M0;
      E_M0:    return E_S1;
      E_S1:    return E_S0;
      E_S0:    return E_CR;
      default: return IDLE;
    endcase
  endfunction

  // Tens positions only take 0-5 so minutes and seconds stay below 60
  function automatic logic is_tens(input state_t s);
    return (s == E_M1) || (s == E_S1);
  endfunction

endpackage

// File: rtl/time_entry_fsm_entry_timer.sv
// rtl/time_entry_fsm_entry_timer.sv - inactivity counter raising expire after TMO_CYCLES idle cycles
module entry_timer #(
  parameter int unsigned TMO_CYCLES = 36_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expire
);
  import time_entry_fsm_pkg::*;

  localparam logic [31:0] LAST = TMO_CYCLES - 32'd1;

  logic [31:0] cnt;

  assign expire = (TMO_CYCLES != 0) && enable && !clear && (cnt == LAST);

  always_ff @(posedge clk) begin
    if (rst || clear || !enable) begin
      cnt <= 32'd0;
    end else if (TMO_CYCLES != 0) begin
      cnt <= cnt + 32'd1;
    end
  end

endmodule

// File: rtl/time_entry_fsm.sv
// rtl/time_entry_fsm.sv - keyboard-driven mm:ss entry with commit to clock or alarm
module time_entry_fsm #(
  parameter int unsigned TMO_CYCLES = 36_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] charData,
  input  logic       det_esc,
  input  logic       det_cr,
  input  logic       det_num,
  input  logic       det_num0to5,
  input  logic       det_A,
  input  logic       det_L,
  input  logic       det_N,
  input  logic       det_S,
  input  logic       det_atSign,
  output logic [3:0] dig_m1,
  output logic [3:0] dig_m0,
  output logic [3:0] dig_s1,
  output logic [3:0] dig_s0,
  output logic       ld_time,
  output logic       ld_alarm,
  output logic       run_en,
  output logic       alarm_en,
  output logic       led_sel,
  output logic       entry_active,
  output logic [2:0] entry_pos
);
  import time_entry_fsm_pkg::*;

  state_t     state;
  target_t    target;
  logic [3:0] shadow [NUM_DIGITS];
  logic       in_entry;
  logic       idle_start;
  logic       take_digit;
  logic       tmr_expire;

  assign in_entry     = (state != IDLE);
  assign entry_active = in_entry;
  assign idle_start   = !in_entry && !det_esc && !det_cr && !det_num && (det_A || det_L);
  assign take_digit   = in_entry && !det_esc && !det_cr && (state != E_CR) &&
                        (is_tens(state) ? det_num0to5 : det_num);

  entry_timer #(.TMO_CYCLES(TMO_CYCLES)) u_timer (
    .clk    (clk),
    .rst    (rst),
    .clear  (idle_start || take_digit),
    .enable (in_entry),
    .expire (tmr_expire)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      target    <= TGT_TIME;
      shadow    <= '{default: 4'd0};
      dig_m1    <= 4'd0;
      dig_m0    <= 4'd0;
      dig_s1    <= 4'd0;
      dig_s0    <= 4'd0;
      ld_time   <= 1'b0;
      ld_alarm  <= 1'b0;
      run_en    <= 1'b0;
      alarm_en  <= 1'b0;
      led_sel   <= 1'b0;
      entry_pos <= 3'd0;
    end else begin
      ld_time  <= 1'b0;
      ld_alarm <= 1'b0;
      if (!in_entry) begin
        // Escape and digits outrank the control keys but do nothing while idle
        if (det_esc) begin
        end else if (det_cr) begin
          run_en <= 1'b0;
        end else if (det_num) begin
        end else if (idle_start) begin
          state     <= E_M1;
          target    <= det_L ? TGT_TIME : TGT_ALARM;
          entry_pos <= 3'd0;
        end else if (det_S) begin
          run_en <= 1'b1;
        end else if (det_N) begin
          led_sel <= ~led_sel;
        end else if (det_atSign) begin
          alarm_en <= ~alarm_en;
        end
      end else if (det_esc || (det_cr && state != E_CR)) begin
        state     <= IDLE;
        entry_pos <= 3'd0;
      end else if (det_cr) begin
        dig_m1    <= shadow[POS_M1];
        dig_m0    <= shadow[POS_M0];
        dig_s1    <= shadow[POS_S1];
        dig_s0    <= shadow[POS_S0];
        ld_time   <= (target == TGT_TIME);
        ld_alarm  <= (target == TGT_ALARM);
        state     <= IDLE;
        entry_pos <= 3'd0;
      end else if (tmr_expire) begin
        state     <= IDLE;
        entry_pos <= 3'd0;
      end else if (take_digit) begin
        shadow[entry_pos[1:0]] <= charData[3:0];
        entry_pos              <= entry_pos + 3'd1;
        state                  <= next_entry(state);
      end
    end
  end

endmodule

// File: tb/tb_time_entry_fsm.sv
// tb/tb_time_entry_fsm.sv - randomized and directed checks of time_entry_fsm against a key-level model
module tb_time_entry_fsm;

  localparam int TMO = 100;
  localparam logic [7:0] K_ESC = 8'h1b;
  localparam logic [7:0] K_CR  = 8'h0d;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] charData = 8'd0;
  logic       det_esc = 0, det_cr = 0, det_num = 0, det_num0to5 = 0;
  logic       det_A = 0, det_L = 0, det_N = 0, det_S = 0, det_atSign = 0;
  logic [3:0] dig_m1, dig_m0, dig_s1, dig_s0;
  logic       ld_time, ld_alarm, run_en, alarm_en, led_sel, entry_active;
  logic [2:0] entry_pos;

  int n_pass = 0;
  int n_total = 0;

  time_entry_fsm #(.TMO_CYCLES(TMO)) dut (
    .clk(clk), .rst(rst), .charData(charData),
    .det_esc(det_esc), .det_cr(det_cr), .det_num(det_num), .det_num0to5(det_num0to5),
    .det_A(det_A), .det_L(det_L), .det_N(det_N), .det_S(det_S), .det_atSign(det_atSign),
    .dig_m1(dig_m1), .dig_m0(dig_m0), .dig_s1(dig_s1), .dig_s0(dig_s0),
    .ld_time(ld_time), .ld_alarm(ld_alarm), .run_en(run_en), .alarm_en(alarm_en),
    .led_sel(led_sel), .entry_active(entry_active), .entry_pos(entry_pos)
  );

  always #5 clk = ~clk;

  // Reference model: entry is a list of accepted digits plus a timestamp of last progress
  int         cyc = 0;
  int         m_last = 0;
  bit         m_entry, m_alarm_tgt, m_run, m_aen, m_led, m_ldt, m_lda;
  int         m_q[$];
  logic [3:0] m_dig [4];

  task automatic model_edge(input logic [7:0] k, input logic r);
    cyc++;
    m_ldt = 0;
    m_lda = 0;
    if (r) begin
      m_entry = 0; m_alarm_tgt = 0; m_run = 0; m_aen = 0; m_led = 0;
      m_q.delete();
      for (int i = 0; i < 4; i++) m_dig[i] = 4'd0;
    end else if (!m_entry) begin
      if (k == K_CR) m_run = 0;
      else if (k == "l" || k == "a") begin
        m_entry = 1; m_alarm_tgt = (k == "a"); m_q.delete(); m_last = cyc;
      end
      else if (k == "s") m_run = 1;
      else if (k == "n") m_led = !m_led;
      else if (k == "@") m_aen = !m_aen;
    end else if (k == K_ESC) begin
      m_entry = 0;
    end else if (k == K_CR) begin
      if (m_q.size() == 4) begin
        for (int i = 0; i < 4; i++) m_dig[i] = m_q[i][3:0];
        m_ldt = !m_alarm_tgt;
        m_lda = m_alarm_tgt;
      end
      m_entry = 0;
    end else if (k >= "0" && k <= "9" && m_q.size() < 4 &&
                 (m_q.size() % 2 == 1 || k <= "5")) begin
      m_q.push_back(int'(k - "0"));
      m_last = cyc;
    end else if (cyc - m_last >= TMO) begin
      m_entry = 0;
    end
  endtask

  function automatic logic [24:0] exp_vec();
    return {m_dig[0], m_dig[1], m_dig[2], m_dig[3], m_ldt, m_lda, m_run, m_aen, m_led,
            m_entry, (m_entry ? 3'(m_q.size()) : 3'd0)};
  endfunction

  function automatic logic [24:0] dut_vec();
    return {dig_m1, dig_m0, dig_s1, dig_s0, ld_time, ld_alarm, run_en, alarm_en, led_sel,
            entry_active, entry_pos};
  endfunction

  task automatic step(input logic [7:0] k, input logic r);
    @(negedge clk);
    rst         = r;
    charData    = k;
    det_esc     = (k == K_ESC);
    det_cr      = (k == K_CR);
    det_num     = (k >= "0" && k <= "9");
    det_num0to5 = (k >= "0" && k <= "5");
    det_A       = (k == "a");
    det_L       = (k == "l");
    det_N       = (k == "n");
    det_S       = (k == "s");
    det_atSign  = (k == "@");
    @(posedge clk);
    model_edge(k, r);
    #1;
    rst = 0; charData = 0; det_esc = 0; det_cr = 0; det_num = 0; det_num0to5 = 0;
    det_A = 0; det_L = 0; det_N = 0; det_S = 0; det_atSign = 0;
  endtask

  task automatic test_reset();
    step(8'd0, 1'b1);
    step("l", 1'b1);
    n_total++;
    if (dut_vec() !== 25'd0) $display("FAIL reset_state: got %h expected %h", dut_vec(), 25'd0);
    else n_pass++;
  endtask

  task automatic test_load_time();
    step("l", 0); step("1", 0); step("2", 0);
    n_total++;
    if (entry_pos !== 3'd2 || entry_active !== 1'b1)
      $display("FAIL time_partial: got pos %0d act %b expected pos 2 act 1", entry_pos, entry_active);
    else n_pass++;
    step("3", 0); step("4", 0); step(K_CR, 0);
    n_total++;
    if ({ld_time, ld_alarm, dig_m1, dig_m0, dig_s1, dig_s0} !== {2'b10, 16'h1234})
      $display("FAIL time_commit: got %b%b %h%h%h%h expected 10 1234",
               ld_time, ld_alarm, dig_m1, dig_m0, dig_s1, dig_s0);
    else n_pass++;
    step(8'd0, 0);
    n_total++;
    if (ld_time !== 1'b0 || entry_active !== 1'b0)
      $display("FAIL time_pulse_once: got ld %b act %b expected 0 0", ld_time, entry_active);
    else n_pass++;
  endtask

  task automatic test_abort();
    step("l", 0); step("1", 0); step("2", 0); step(K_ESC, 0);
    n_total++;
    if ({entry_active, ld_time, ld_alarm, entry_pos, dig_m1, dig_m0, dig_s1, dig_s0} !== {6'd0, 16'h1234})
      $display("FAIL abort_esc: got %h expected %h",
               {entry_active, ld_time, ld_alarm, entry_pos, dig_m1, dig_m0, dig_s1, dig_s0}, {6'd0, 16'h1234});
    else n_pass++;
    step("l", 0); step("1", 0); step("2", 0); step(K_CR, 0);
    n_total++;
    if ({entry_active, ld_time, ld_alarm, entry_pos, dig_m1, dig_m0, dig_s1, dig_s0} !== {6'd0, 16'h1234})
      $display("FAIL abort_cr: got %h expected %h",
               {entry_active, ld_time, ld_alarm, entry_pos, dig_m1, dig_m0, dig_s1, dig_s0}, {6'd0, 16'h1234});
    else n_pass++;
    step(8'd0, 0);
    n_total++;
    if (ld_time !== 1'b0 || ld_alarm !== 1'b0)
      $display("FAIL abort_no_late_pulse: got %b%b expected 00", ld_time, ld_alarm);
    else n_pass++;
  endtask

  task automatic test_load_alarm();
    step("a", 0); step("6", 0);
    n_total++;
    if (entry_pos !== 3'd0 || entry_active !== 1'b1)
      $display("FAIL alarm_reject6: got pos %0d act %b expected pos 0 act 1", entry_pos, entry_active);
    else n_pass++;
    step("5", 0); step("9", 0); step("0", 0); step("0", 0); step(K_CR, 0);
    n_total++;
    if ({ld_time, ld_alarm, dig_m1, dig_m0, dig_s1, dig_s0} !== {2'b01, 16'h5900})
      $display("FAIL alarm_commit: got %b%b %h%h%h%h expected 01 5900",
               ld_time, ld_alarm, dig_m1, dig_m0, dig_s1, dig_s0);
    else n_pass++;
  endtask

  task automatic test_idle_controls();
    step("s", 0);
    n_total++;
    if (run_en !== 1'b1) $display("FAIL ctl_run_on: got %b expected 1", run_en); else n_pass++;
    step("@", 0);
    n_total++;
    if (alarm_en !== 1'b1) $display("FAIL ctl_alarm_on: got %b expected 1", alarm_en); else n_pass++;
    step("@", 0);
    n_total++;
    if (alarm_en !== 1'b0) $display("FAIL ctl_alarm_off: got %b expected 0", alarm_en); else n_pass++;
    step("n", 0);
    n_total++;
    if (led_sel !== 1'b1) $display("FAIL ctl_led: got %b expected 1", led_sel); else n_pass++;
    step("s", 0); step("l", 0); step("s", 0); step("n", 0); step(K_ESC, 0);
    n_total++;
    if ({run_en, led_sel} !== 2'b11) $display("FAIL ctl_in_entry: got %b expected 11", {run_en, led_sel});
    else n_pass++;
    step(K_CR, 0);
    n_total++;
    if (run_en !== 1'b0) $display("FAIL ctl_run_off: got %b expected 0", run_en); else n_pass++;
  endtask

  task automatic test_back_to_back();
    step("l", 0); step("0", 0); step("9", 0); step("5", 0); step("9", 0); step(K_CR, 0);
    n_total++;
    if ({ld_time, dig_m1, dig_m0, dig_s1, dig_s0} !== {1'b1, 16'h0959})
      $display("FAIL b2b_commit: got %b %h%h%h%h expected 1 0959", ld_time, dig_m1, dig_m0, dig_s1, dig_s0);
    else n_pass++;
    step("a", 0);
    n_total++;
    if ({ld_time, ld_alarm, entry_active} !== 3'b001)
      $display("FAIL b2b_restart: got %b expected 001", {ld_time, ld_alarm, entry_active});
    else n_pass++;
    step(K_ESC, 0);
  endtask

  task automatic test_timeout();
    step("l", 0); step("1", 0);
    for (int i = 0; i < TMO - 1; i++) step(8'd0, 0);
    n_total++;
    if (entry_active !== 1'b1 || entry_pos !== 3'd1)
      $display("FAIL tmo_before: got act %b pos %0d expected act 1 pos 1", entry_active, entry_pos);
    else n_pass++;
    step(8'd0, 0);
    n_total++;
    if ({entry_active, entry_pos, ld_time, ld_alarm} !== 6'd0)
      $display("FAIL tmo_expire: got %b expected 000000", {entry_active, entry_pos, ld_time, ld_alarm});
    else n_pass++;
    step("s", 0); step("l", 0); step("1", 0); step("2", 0); step("3", 1);
    n_total++;
    if (dut_vec() !== 25'd0) $display("FAIL rst_mid_entry: got %h expected %h", dut_vec(), 25'd0);
    else n_pass++;
  endtask

  function automatic logic [7:0] pick_key();
    logic [7:0] tab [18] = '{"l", "a", "0", "1", "2", "3", "4", "5", "6", "7", "8", "9",
                             "s", "n", "@", K_ESC, K_CR, 8'd0};
    if (m_entry && m_q.size() == 4 && $urandom_range(0, 1) == 0) return K_CR;
    if (m_entry && $urandom_range(0, 2) != 0) return tab[$urandom_range(2, 11)];
    return tab[$urandom_range(0, 17)];
  endfunction

  task automatic test_random();
    int errs = 0;
    for (int i = 0; i < 900; i++) begin
      int runlen = ($urandom_range(0, 89) == 0) ? TMO + 5 : 1;
      for (int j = 0; j < runlen; j++) begin
        if (runlen > 1) step(8'd0, 0);
        else step(pick_key(), ($urandom_range(0, 299) == 0));
        n_total++;
        if (dut_vec() !== exp_vec()) begin
          if (errs < 10) $display("FAIL random_cycle%0d: got %h expected %h", cyc, dut_vec(), exp_vec());
          errs++;
        end else n_pass++;
      end
    end
  endtask

  initial begin
    test_reset();
    test_load_time();
    test_abort();
    test_load_alarm();
    test_idle_controls();
    test_back_to_back();
    test_timeout();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
